// File: rtl/ptc_power_sequencer.sv
// Power Timing Crate supply sequencer: 2V5 rail, then 3V3 rail, then WIB slots one at a time,
// with a reverse-order timed shutdown and sticky per-slot overcurrent latching.
module ptc_power_sequencer #(
    parameter int unsigned N_WIB = 6,
    parameter int unsigned DLY_W = 24
) (
    input  logic             clk_axi,
    input  logic             rst_axi,
    input  logic             enable_in,
    input  logic [N_WIB-1:0] wib_mask_in,
    input  logic [DLY_W-1:0] rail_delay_in,
    input  logic [DLY_W-1:0] wib_delay_in,
    input  logic [N_WIB-1:0] wib_fault_in,
    input  logic             fault_clear_in,
    output logic             local_2v5_en_out,
    output logic             local_3v3_en_out,
    output logic [N_WIB-1:0] wib_en_out,
    output logic [N_WIB-1:0] wib_on_led_out,
    output logic [N_WIB-1:0] fault_latched_out,
    output logic [2:0]       state_out,
    output logic             busy_out
);

    localparam int unsigned IDX_W = (N_WIB > 1) ? $clog2(N_WIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WIB - 1);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_UP_2V5   = 3'd1,
        S_UP_3V3   = 3'd2,
        S_WIB_SCAN = 3'd3,
        S_WIB_WAIT = 3'd4,
        S_ON       = 3'd5,
        S_DN_WIB   = 3'd6,
        S_DN_3V3   = 3'd7
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [DLY_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_2v5, w_2v5_nxt;
    logic             r_3v3, w_3v3_nxt;
    logic             r_busy;
    logic [N_WIB-1:0] r_wib_en, w_wib_base, w_wib_en_nxt;
    logic [N_WIB-1:0] r_fault, w_fault_nxt;
    logic [N_WIB-1:0] w_eligible;
    logic             w_slot_ok;
    logic             w_cnt_zero;
    logic             w_shutdown;

    // Next-state, counter, slot index and enable decisions
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_2v5_nxt   = r_2v5;
        w_3v3_nxt   = r_3v3;
        w_wib_base  = r_wib_en;

        // A fault asserted this cycle always beats a simultaneous clear
        w_fault_nxt = (r_fault & ~({N_WIB{fault_clear_in}} & ~wib_fault_in)) | wib_fault_in;
        w_eligible  = wib_mask_in & ~r_fault & ~r_wib_en;
        w_slot_ok   = w_eligible[r_idx] & ~wib_fault_in[r_idx];
        w_cnt_zero  = (r_cnt == '0);
        w_shutdown  = !enable_in && (r_state != S_OFF) &&
                      (r_state != S_DN_WIB) && (r_state != S_DN_3V3);

        if (w_shutdown) begin
            w_wib_base  = '0;
            w_cnt_nxt   = rail_delay_in;
            w_state_nxt = S_DN_WIB;
        end else begin
            unique case (r_state)
                S_OFF: begin
                    if (enable_in) begin
                        w_2v5_nxt   = 1'b1;
                        w_cnt_nxt   = rail_delay_in;
                        w_state_nxt = S_UP_2V5;
                    end
                end
                S_UP_2V5: begin
                    if (w_cnt_zero) begin
                        w_3v3_nxt   = 1'b1;
                        w_cnt_nxt   = rail_delay_in;
                        w_state_nxt = S_UP_3V3;
                    end else begin
                        w_cnt_nxt = r_cnt - DLY_W'(1);
                    end
                end
                S_UP_3V3: begin
                    if (w_cnt_zero) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_WIB_SCAN;
                    end else begin
                        w_cnt_nxt = r_cnt - DLY_W'(1);
                    end
                end
                S_WIB_SCAN: begin
                    if (w_slot_ok) begin
                        w_wib_base[r_idx] = 1'b1;
                        w_cnt_nxt         = wib_delay_in;
                        w_state_nxt       = S_WIB_WAIT;
                    end else if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_ON;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
                S_WIB_WAIT: begin
                    if (!w_cnt_zero) begin
                        w_cnt_nxt = r_cnt - DLY_W'(1);
                    end else if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_ON;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = S_WIB_SCAN;
                    end
                end
                S_ON: begin
                    if (|w_eligible) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_WIB_SCAN;
                    end
                end
                S_DN_WIB: begin
                    if (w_cnt_zero) begin
                        w_3v3_nxt   = 1'b0;
                        w_cnt_nxt   = rail_delay_in;
                        w_state_nxt = S_DN_3V3;
                    end else begin
                        w_cnt_nxt = r_cnt - DLY_W'(1);
                    end
                end
                S_DN_3V3: begin
                    if (w_cnt_zero) begin
                        w_2v5_nxt   = 1'b0;
                        w_state_nxt = S_OFF;
                    end else begin
                        w_cnt_nxt = r_cnt - DLY_W'(1);
                    end
                end
                default: w_state_nxt = S_OFF;
            endcase
        end

        // Mask removal and live faults override any enable in every state
        w_wib_en_nxt = w_wib_base & wib_mask_in & ~wib_fault_in;
    end

    always_ff @(posedge clk_axi) begin
        if (rst_axi) begin
            r_state  <= S_OFF;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_2v5    <= 1'b0;
            r_3v3    <= 1'b0;
            r_wib_en <= '0;
            r_fault  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_2v5    <= w_2v5_nxt;
            r_3v3    <= w_3v3_nxt;
            r_wib_en <= w_wib_en_nxt;
            r_fault  <= w_fault_nxt;
            r_busy   <= (w_state_nxt != S_OFF) && (w_state_nxt != S_ON);
        end
    end

    assign local_2v5_en_out  = r_2v5;
    assign local_3v3_en_out  = r_3v3;
    assign wib_en_out        = r_wib_en;
    assign wib_on_led_out    = r_wib_en;
    assign fault_latched_out = r_fault;
    assign state_out         = r_state;
    assign busy_out          = r_busy;

endmodule

// File: tb/tb_ptc_power_sequencer.sv
// Bench for ptc_power_sequencer: directed timing scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the sequencing rules.
module tb_ptc_power_sequencer;

    logic        clk_axi = 1'b0;
    logic        rst_axi;
    logic        enable_in;
    logic [5:0]  wib_mask_in;
    logic [23:0] rail_delay_in;
    logic [23:0] wib_delay_in;
    logic [5:0]  wib_fault_in;
    logic        fault_clear_in;
    logic        local_2v5_en_out;
    logic        local_3v3_en_out;
    logic [5:0]  wib_en_out;
    logic [5:0]  wib_on_led_out;
    logic [5:0]  fault_latched_out;
    logic [2:0]  state_out;
    logic        busy_out;

    int checks   = 0;
    int failures = 0;

    // Model state
    int         m_st;
    int         m_idx;
    int         m_cnt;
    logic       m_25;
    logic       m_33;
    logic [5:0] m_en;
    logic [5:0] m_flt;
    logic       m_busy;

    ptc_power_sequencer dut (
        .clk_axi          (clk_axi),
        .rst_axi          (rst_axi),
        .enable_in        (enable_in),
        .wib_mask_in      (wib_mask_in),
        .rail_delay_in    (rail_delay_in),
        .wib_delay_in     (wib_delay_in),
        .wib_fault_in     (wib_fault_in),
        .fault_clear_in   (fault_clear_in),
        .local_2v5_en_out (local_2v5_en_out),
        .local_3v3_en_out (local_3v3_en_out),
        .wib_en_out       (wib_en_out),
        .wib_on_led_out   (wib_on_led_out),
        .fault_latched_out(fault_latched_out),
        .state_out        (state_out),
        .busy_out         (busy_out)
    );

    always #5 clk_axi = ~clk_axi;

    task automatic tick();
        @(posedge clk_axi);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (state_out !== s && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (state_out !== s) begin
            failures++;
            $display("FAIL %s_timeout state=%0d exp=%0d", name, state_out, s);
        end
    endtask

    task automatic test_reset();
        rst_axi = 1'b1; enable_in = 1'b1; wib_mask_in = 6'h3f;
        rail_delay_in = 24'd3; wib_delay_in = 24'd2;
        wib_fault_in = 6'h00; fault_clear_in = 1'b0;
        tick(); tick();
        checks++;
        if ({local_2v5_en_out, local_3v3_en_out, wib_en_out, wib_on_led_out,
             fault_latched_out, state_out, busy_out} !== 24'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {local_2v5_en_out, local_3v3_en_out,
                     wib_en_out, wib_on_led_out, fault_latched_out, state_out, busy_out});
        end
    endtask

    task automatic test_power_up();
        enable_in = 1'b0; wib_mask_in = 6'b000101;
        tick();
        rst_axi = 1'b0;
        tick();
        enable_in = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            tick();
            checks++;
            if (wib_on_led_out !== wib_en_out) begin
                failures++;
                $display("FAIL pu_led edge=%0d led=%b en=%b", e, wib_on_led_out, wib_en_out);
            end
            if (e == 1) begin
                checks++;
                if (local_2v5_en_out !== 1'b1) begin failures++; $display("FAIL pu_2v5 got=%b exp=1", local_2v5_en_out); end
            end
            if (e == 4 || e == 5) begin
                checks++;
                if (local_3v3_en_out !== (e == 5)) begin failures++; $display("FAIL pu_3v3 edge=%0d got=%b", e, local_3v3_en_out); end
            end
            if (e == 9 || e == 10 || e == 14 || e == 15) begin
                checks++;
                if (wib_en_out !== ((e == 9) ? 6'b000000 : (e == 15) ? 6'b000101 : 6'b000001)) begin
                    failures++; $display("FAIL pu_wib edge=%0d got=%b", e, wib_en_out);
                end
            end
            if (e == 20) begin
                checks++;
                if (state_out !== 3'd3 || busy_out !== 1'b1) begin failures++; $display("FAIL pu_scan state=%0d busy=%b exp=3/1", state_out, busy_out); end
            end
            if (e >= 21) begin
                checks++;
                if (state_out !== 3'd5 || busy_out !== 1'b0 || wib_en_out !== 6'b000101) begin
                    failures++; $display("FAIL pu_on edge=%0d state=%0d busy=%b en=%b", e, state_out, busy_out, wib_en_out);
                end
            end
        end
    endtask

    task automatic test_power_down();
        enable_in = 1'b0;
        tick();
        checks++;
        if (wib_en_out !== 6'h00 || state_out !== 3'd6 || busy_out !== 1'b1 || local_3v3_en_out !== 1'b1) begin
            failures++; $display("FAIL pd_start en=%b state=%0d busy=%b 3v3=%b", wib_en_out, state_out, busy_out, local_3v3_en_out);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 3 || k == 4) begin
                checks++;
                if (local_3v3_en_out !== (k == 3)) begin failures++; $display("FAIL pd_3v3 n+%0d got=%b", k, local_3v3_en_out); end
            end
            if (k == 7 || k == 8) begin
                checks++;
                if (local_2v5_en_out !== (k == 7)) begin failures++; $display("FAIL pd_2v5 n+%0d got=%b", k, local_2v5_en_out); end
            end
        end
        checks++;
        if (state_out !== 3'd0 || busy_out !== 1'b0) begin failures++; $display("FAIL pd_off state=%0d busy=%b", state_out, busy_out); end
    endtask

    task automatic test_fault();
        wib_mask_in = 6'h3f;
        enable_in = 1'b1;
        tick();
        wait_state(3'd5, 200, "fault_on");
        checks++;
        if (wib_en_out !== 6'h3f) begin failures++; $display("FAIL flt_allon got=%b exp=111111", wib_en_out); end
        wib_fault_in = 6'b001000;
        tick();
        checks++;
        if (wib_en_out !== 6'b110111 || fault_latched_out !== 6'b001000) begin
            failures++; $display("FAIL flt_latch en=%b flt=%b", wib_en_out, fault_latched_out);
        end
        fault_clear_in = 1'b1;
        tick();
        checks++;
        if (fault_latched_out !== 6'b001000) begin failures++; $display("FAIL flt_clear_blocked got=%b exp=001000", fault_latched_out); end
        wib_fault_in = 6'h00; fault_clear_in = 1'b0;
        repeat (5) tick();
        checks++;
        if (wib_en_out !== 6'b110111 || state_out !== 3'd5 || fault_latched_out !== 6'b001000) begin
            failures++; $display("FAIL flt_hold en=%b state=%0d flt=%b", wib_en_out, state_out, fault_latched_out);
        end
        fault_clear_in = 1'b1;
        tick();
        fault_clear_in = 1'b0;
        checks++;
        if (fault_latched_out !== 6'h00) begin failures++; $display("FAIL flt_cleared got=%b exp=000000", fault_latched_out); end
        tick();
        checks++;
        if (state_out !== 3'd3 || wib_en_out !== 6'b110111) begin failures++; $display("FAIL flt_rescan state=%0d en=%b", state_out, wib_en_out); end
        wait_state(3'd5, 100, "flt_reon");
        checks++;
        if (wib_en_out !== 6'h3f) begin failures++; $display("FAIL flt_reenable got=%b exp=111111", wib_en_out); end
    endtask

    task automatic test_mask_change();
        wib_mask_in = 6'b111101;
        tick();
        checks++;
        if (wib_en_out !== 6'b111101 || state_out !== 3'd5) begin failures++; $display("FAIL mask_drop en=%b state=%0d", wib_en_out, state_out); end
        wib_mask_in = 6'h3f;
        tick();
        checks++;
        if (state_out !== 3'd3) begin failures++; $display("FAIL mask_rescan state=%0d exp=3", state_out); end
        wait_state(3'd5, 100, "mask_reon");
        checks++;
        if (wib_en_out !== 6'h3f) begin failures++; $display("FAIL mask_reenable got=%b exp=111111", wib_en_out); end
    endtask

    task automatic test_reset_mid();
        rst_axi = 1'b1;
        tick();
        rst_axi = 1'b0;
        wait_state(3'd4, 100, "rstmid_wait");
        rst_axi = 1'b1;
        tick();
        rst_axi = 1'b0;
        checks++;
        if ({local_2v5_en_out, local_3v3_en_out, wib_en_out, wib_on_led_out,
             fault_latched_out, state_out, busy_out} !== 24'h0) begin
            failures++;
            $display("FAIL rstmid_outputs 2v5=%b 3v3=%b en=%b state=%0d busy=%b",
                     local_2v5_en_out, local_3v3_en_out, wib_en_out, state_out, busy_out);
        end
    endtask

    // Applies the sequencing rules for one clock edge using the inputs currently driven
    task automatic model_step();
        logic [5:0] nen;
        logic [5:0] elig;
        int         nst;
        int         nidx;
        int         ncnt;
        logic       n25;
        logic       n33;
        if (rst_axi) begin
            m_st = 0; m_idx = 0; m_cnt = 0; m_25 = 0; m_33 = 0;
            m_en = '0; m_flt = '0; m_busy = 0;
            return;
        end
        nen = m_en; nst = m_st; nidx = m_idx; ncnt = m_cnt; n25 = m_25; n33 = m_33;
        elig = wib_mask_in & ~m_flt & ~m_en;
        if (!enable_in && m_st >= 1 && m_st <= 5) begin
            nen = '0; ncnt = int'(rail_delay_in); nst = 6;
        end else if (m_st == 0) begin
            if (enable_in) begin n25 = 1; ncnt = int'(rail_delay_in); nst = 1; end
        end else if (m_st == 3) begin
            if (elig[m_idx] && !wib_fault_in[m_idx]) begin
                nen[m_idx] = 1'b1; ncnt = int'(wib_delay_in); nst = 4;
            end else if (m_idx == 5) nst = 5;
            else nidx = m_idx + 1;
        end else if (m_st == 5) begin
            if (elig != 0) begin nidx = 0; nst = 3; end
        end else if (m_cnt > 0) begin
            ncnt = m_cnt - 1;
        end else begin
            if (m_st == 1) begin n33 = 1; ncnt = int'(rail_delay_in); nst = 2; end
            else if (m_st == 2) begin nidx = 0; nst = 3; end
            else if (m_st == 4) begin
                if (m_idx == 5) nst = 5;
                else begin nidx = m_idx + 1; nst = 3; end
            end
            else if (m_st == 6) begin n33 = 0; ncnt = int'(rail_delay_in); nst = 7; end
            else begin n25 = 0; nst = 0; end
        end
        if (fault_clear_in) m_flt = m_flt & wib_fault_in;
        m_flt = m_flt | wib_fault_in;
        m_en  = nen & wib_mask_in & ~wib_fault_in;
        m_st = nst; m_idx = nidx; m_cnt = ncnt; m_25 = n25; m_33 = n33;
        m_busy = !(nst == 0 || nst == 5);
    endtask

    task automatic test_random();
        logic [23:0] exp_v;
        logic [23:0] got_v;
        enable_in = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rst_axi = (i == 0) || ($urandom_range(0, 999) < 3);
            if ($urandom_range(0, 99) < 2) enable_in = ~enable_in;
            if ($urandom_range(0, 99) < 5) wib_mask_in = 6'($urandom);
            if ($urandom_range(0, 99) < 10) rail_delay_in = 24'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 10) wib_delay_in = 24'($urandom_range(0, 3));
            wib_fault_in = ($urandom_range(0, 99) < 4) ? (6'($urandom) & 6'($urandom)) : 6'h00;
            fault_clear_in = ($urandom_range(0, 99) < 6);
            model_step();
            tick();
            exp_v = {m_25, m_33, m_en, m_en, m_flt, 3'(m_st), m_busy};
            got_v = {local_2v5_en_out, local_3v3_en_out, wib_en_out, wib_on_led_out,
                     fault_latched_out, state_out, busy_out};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL rand_cycle%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        rst_axi = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down();
        test_fault();
        test_mask_change();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ptc_power_sequencer.md
Name: ptc_power_sequencer

Overview:
- Controls the power-up and power-down order of the Power Timing Crate supplies: local 2V5 rail, then local 3V3 rail, then the six WIB enables one at a time.
- Configured from the AXI register bank: master enable, per-WIB request mask and delays.
- Drives the rail enables, WIB enables and WIB-on LEDs.
- Latches per-WIB overcurrent faults and keeps faulted WIBs powered off.

Parameters:
N_WIB, 6, number of WIB slots sequenced
DLY_W, 24, width of delay registers and the internal down-counter

Ports:
clk_axi  in  1  AXI clock; the only clock
rst_axi  in  1  synchronous active-high reset
enable_in  in  1  master power enable (level)
wib_mask_in  in  N_WIB  requested WIB slots
rail_delay_in  in  DLY_W  dwell after each rail change (D gives D+1 cycles)
wib_delay_in  in  DLY_W  dwell after each WIB turn-on (D gives D+1 cycles)
wib_fault_in  in  N_WIB  active-high overcurrent flags
fault_clear_in  in  1  single-cycle pulse that clears latched faults
local_2v5_en_out  out  1  2V5 rail enable
local_3v3_en_out  out  1  3V3 rail enable
wib_en_out  out  N_WIB  WIB power enables
wib_on_led_out  out  N_WIB  equal to wib_en_out (same register value)
fault_latched_out  out  N_WIB  sticky fault flags
state_out  out  3  current FSM state code
busy_out  out  1  1 when state is not OFF and not ON

Behaviour:
- Reset: every output is 0, state is OFF, idx is 0, counter is 0. Reset mid-sequence drops all enables at the next edge.
- All outputs are registered. A state change decided at edge k is visible after edge k.
- Counter: loaded with D when entering a timed state. It decrements each cycle. The state exits on the edge where the counter is 0.
- State encodings: OFF=0, UP_2V5=1, UP_3V3=2, WIB_SCAN=3, WIB_WAIT=4, ON=5, DN_WIB=6, DN_3V3=7.
- OFF: if enable_in=1, set 2V5, load rail_delay, go to UP_2V5.
- UP_2V5: when the counter is 0, set 3V3, load rail_delay, go to UP_3V3.
- UP_3V3: when the counter is 0, set idx=0, go to WIB_SCAN.
- WIB_SCAN: examine slot idx.
  - If mask[idx]=1, fault_latched[idx]=0 and wib_en[idx]=0: set wib_en[idx], load wib_delay, go to WIB_WAIT.
  - Otherwise skip the slot: idx++, or go to ON if idx=N_WIB-1. A skip takes one cycle.
- WIB_WAIT: when the counter is 0, go to ON if idx=N_WIB-1; otherwise idx++ and go to WIB_SCAN.
- ON: if any slot has mask=1, fault=0 and en=0, set idx=0 and go to WIB_SCAN. Slots already on are skipped.
- enable_in=0 in any state except OFF or DN_*: clear all wib_en, load rail_delay, go to DN_WIB. This applies in UP_2V5 and UP_3V3 too.
- DN_WIB: when the counter is 0, clear 3V3, load rail_delay, go to DN_3V3.
- DN_3V3: when the counter is 0, clear 2V5, go to OFF.
- enable_in returning to 1 during DN_*: ignored. The shutdown completes first; OFF then restarts on the next cycle.
- Mask bit cleared in any state: the corresponding wib_en clears at the next edge. Sequencing continues.
- Fault: wib_fault_in[i]=1 at an edge sets fault_latched[i] and clears wib_en[i] at that edge, in any state.
  - A fault during WIB_WAIT on the active slot does not shorten the wait.
- fault_clear_in=1: clears fault_latched[i] only where wib_fault_in[i]=0. When both are active in the same cycle, the fault wins.
- In WIB_SCAN, wib_en is never set in the same cycle that mask or fault disqualifies the slot.
- Delay 0 gives a 1-cycle dwell. The counter never wraps because loads only happen on state entry.

Test Plan:
- Power-up: rail_delay=3, wib_delay=2, mask=000101, enable_in rises and is sampled at edge 1.
  - Required: 2V5 at edge 1, 3V3 at edge 5, wib_en[0] at edge 10, wib_en[2] at edge 15.
  - Required: state_out=5 and busy_out=0 by edge 21; wib_on_led_out equals wib_en_out throughout.
- Power-down from ON with the same delays: enable_in=0 at edge n.
  - Required: wib_en=0 at n; 3V3 clears at n+4; 2V5 clears at n+8; state OFF.
- Fault: in ON with mask=111111, pulse wib_fault_in[3].
  - Required: wib_en[3]=0 and fault_latched[3]=1 at that edge; no re-enable while the mask is unchanged.
- Fault clear: fault_clear_in together with an active fault[3] leaves the latch set. A clear after the fault drops resets the latch, then WIB_SCAN re-enables slot 3 only.
- Mask change: in ON, clearing mask bit 1 drops wib_en[1] within 1 cycle. Setting it again returns to WIB_SCAN and re-enables slot 1 only.
- Reset mid-sequence: rst_axi asserted during WIB_WAIT drops all outputs to 0 at the next edge, with state_out=0.
